// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg: Funct3 encodings, FSM state type and Funct3 legality helper.
// Rev 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array: DEPTH_WORDS x 32 storage, byte write enables, synchronous read.
// Rev 1.0
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder: stalling load/store responder with lane steering.
// Optional DMEM_MISALIGN_CHECK_EN faults misaligned half/word accesses.
// Rev 1.0
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Stall,
  output logic        Done,
  output logic        Fault
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic          store_q;

  logic          w_req, w_access, w_in_done;
  logic          w_store, w_fault, w_misalign;
  logic [2:0]    w_f3;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata, w_wsteer, w_rword, w_ext;
  logic [3:0]    w_be;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_unused_addr;

  assign w_req         = MemRead | MemWrite;
  assign w_unused_addr = ^Addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && w_req) begin
        addr_q  <= Addr[AW+1:0];
        f3_q    <= Funct3;
        wdata_q <= WData;
        store_q <= MemWrite;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          cnt_d = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d  = DONE;
            w_access = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d  = DONE;
          w_access = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only a zero-wait access reaches the array straight from IDLE, before latching.
  assign w_store = (state_q == IDLE) ? MemWrite          : store_q;
  assign w_f3    = (state_q == IDLE) ? Funct3            : f3_q;
  assign w_addr  = (state_q == IDLE) ? Addr[AW+1:0]      : addr_q;
  assign w_wdata = (state_q == IDLE) ? WData             : wdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = !funct3_legal(w_store, w_f3) || w_misalign;

  always_comb begin
    w_be     = 4'b0000;
    w_wsteer = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wsteer = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wsteer = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .be_i    (w_be & {4{w_access && w_store && !w_fault && !reset}}),
    .re_i    (w_access && !w_store && !w_fault && !reset),
    .idx_i   (w_addr[AW+1:2]),
    .wdata_i (w_wsteer),
    .rdata_o (w_rword)
  );

  assign w_byte = w_rword[{addr_q[1:0], 3'b000} +: 8];
  assign w_half = addr_q[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ext = 32'd0;
    case (f3_q)
      F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
      F3_LW:   w_ext = w_rword;
      F3_LBU:  w_ext = {24'd0, w_byte};
      F3_LHU:  w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
  end

  assign w_in_done = (state_q == DONE) && !reset;
  assign Done      = w_in_done;
  assign Fault     = w_in_done && w_fault;
  assign RData     = (w_in_done && !store_q && !w_fault) ? w_ext : 32'd0;
  assign Stall     = !reset && (((state_q == IDLE) && w_req) || (state_q == WAIT));

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the data array (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning extra access wait states in the range 0..15.
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port MemRead  input  1  is the load request from the control unit.
REQ-006 Port MemWrite  input  1  is the store request from the control unit.
REQ-007 Port Funct3  input  3  is the access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores, 000 sb, 001 sh, 010 sw.
REQ-008 Port Addr  input  32  is the byte address from the ALU result.
REQ-009 Port WData  input  32  is the store data (rs2); the low byte or halfword is used for sb/sh.
REQ-010 Port RData  output  32  is the load result, extended per Funct3.
REQ-011 Port Stall  output  1  freezes the PC and pipeline while high.
REQ-012 Port Done  output  1  is a one-cycle pulse when the access completes.
REQ-013 Port Fault  output  1  is valid with Done; it flags an illegal or rejected access.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-015 In IDLE, when MemRead or MemWrite is high, the block SHALL latch Addr, Funct3, WData and the request type, then go to WAIT, or to DONE if WAIT_CYCLES=0.
REQ-016 Stall SHALL be combinational: high when in IDLE with a request present, high in WAIT, and low otherwise.
REQ-017 WAIT SHALL count WAIT_CYCLES cycles, then go to DONE; the total stall is WAIT_CYCLES+1 cycles.
REQ-018 On the edge entering DONE, the array write (stores) or synchronous read (loads) SHALL occur once.
REQ-019 In DONE, Done SHALL be 1, RData and Fault SHALL be valid, the state SHALL return to IDLE unconditionally, and requests present in DONE SHALL be ignored.
REQ-020 When MemRead and MemWrite are both high, MemWrite SHALL take precedence.
REQ-021 Loads SHALL be extended as follows: lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-022 The byte lane SHALL be selected by Addr[1:0] and the halfword lane by Addr[1].
REQ-023 The word index SHALL be Addr[$clog2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-024 Illegal Funct3 (011, 110, 111, and 1xx for stores) SHALL set Fault=1, suppress the write, and drive RData=0, with the same latency as a legal access.
REQ-025 RData SHALL be 0 in every cycle except DONE of a legal load.

Reset
REQ-026 While reset is high, the block SHALL be in IDLE with Stall=0, Done=0, Fault=0, RData=0, and the wait counter=0.
REQ-027 A reset asserted during WAIT SHALL abort the access, drop the pending store, and avoid any Done pulse.
REQ-028 Reset SHALL NOT clear the array contents.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN, when defined, SHALL set Fault=1 with no write and RData=0 for lh/lhu/sh with Addr[0]=1 and for lw/sw with Addr[1:0]!=00.
REQ-030 When DMEM_MISALIGN_CHECK_EN is undefined, the block SHALL ignore Addr[0] for halfword accesses and Addr[1:0] for word accesses (forced alignment), and Fault SHALL flag only illegal Funct3.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the Funct3 load/store localparams and the state enum typedef (IDLE/WAIT/DONE).
REQ-032 The storage SHALL be sub-module dmem_array: DEPTH_WORDS x 32, 4-bit byte write-enable, synchronous read, and no reset.
REQ-033 The FSM, lane steering and extension logic SHALL reside in data_mem_responder.

Verification
REQ-034 sw with Addr=0x10, WData=0xDEADBEEF, WAIT_CYCLES=1, then lw Addr=0x10 -> each access stalls 2 cycles, Done pulses once per access, and the load returns RData=0xDEADBEEF with Fault=0.
REQ-035 lb and lbu at Addr=0x13 after REQ-034 -> RData=0xFFFFFFDE then 0x000000DE; sh WData=0x1234 at Addr=0x12 then lw 0x10 -> RData=0x1234BEEF.
REQ-036 Funct3=011 load at Addr=0x20 -> Fault=1, RData=0, latency unchanged; Funct3=011 store -> Fault=1 and the memory word remains unchanged.
REQ-037 Misaligned lw at Addr=0x11 with the macro defined -> Fault=1 and RData=0; with the macro undefined -> Fault=0 and RData=mem[0x10].
REQ-038 Reset asserted in WAIT of sw Addr=0x30 WData=0xAAAA5555 -> no Done pulse, mem[0x30] unchanged, and Stall=0 in the cycle after reset.
REQ-039 WAIT_CYCLES=0 with MemRead and MemWrite both high and Addr=DEPTH_WORDS*4+4 -> a 1-cycle stall, the write lands at word index 1, and back-to-back requests in DONE are ignored.
